// File: rtl/countdown_timer.sv
// Loadable, prescaled down-counter with one-cycle done pulse and optional auto-reload.
// Counting advances once every prescale+1 clocks while running and not paused.
module countdown_timer #(
    parameter int WIDTH       = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [WIDTH-1:0]       load_val,
    input  logic [PRESC_WIDTH-1:0] prescale,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   pause,
    input  logic                   auto_reload,
    output logic [WIDTH-1:0]       count,
    output logic                   busy,
    output logic                   done
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2
    } state_t;

    state_t                 state;
    logic [PRESC_WIDTH-1:0] pcnt;
    logic [PRESC_WIDTH-1:0] presc_reg;
    logic [WIDTH-1:0]       reload_reg;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            pcnt       <= '0;
            reload_reg <= '0;
            presc_reg  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            if (stop) begin
                state <= IDLE;
                busy  <= 1'b0;
            end else if (start) begin
                count      <= load_val;
                reload_reg <= load_val;
                presc_reg  <= prescale;
                pcnt       <= '0;
                if (load_val != '0) begin
                    state <= RUN;
                    busy  <= 1'b1;
                end else begin
                    // zero-length timer completes immediately without leaving IDLE
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                end
            end else if (state != IDLE) begin
                if (pause) begin
                    state <= PAUSED;
                    busy  <= 1'b1;
                end else begin
                    // releasing pause resumes counting on this same edge
                    state <= RUN;
                    busy  <= 1'b1;
                    if (pcnt == presc_reg) begin
                        pcnt <= '0;
                        if (count == WIDTH'(1)) begin
                            done <= 1'b1;
                            if (auto_reload) begin
                                count <= reload_reg;
                            end else begin
                                count <= '0;
                                state <= IDLE;
                                busy  <= 1'b0;
                            end
                        end else if (count > WIDTH'(1)) begin
                            count <= count - WIDTH'(1);
                        end
                    end else begin
                        pcnt <= pcnt + PRESC_WIDTH'(1);
                    end
                end
            end
        end
    end

endmodule
